// File: rtl/ts_frame_scheduler.sv
// rtl/ts_frame_scheduler.sv - round-robin TS channel to BB-frame data-field scheduler (SYNCD enabled by TS_SCHED_SYNCD_EN)
module ts_frame_scheduler #(
    parameter int N_CH = 2,
    parameter int CH_W = 3
) (
    input  logic                RST,
    input  logic                DCLK_IN,
    input  logic                FRAME_REQ,
    input  logic [15:0]         DFL,
    input  logic                NM_or_HEM,
    input  logic [N_CH-1:0]     SYNC_FOUND,
    input  logic [N_CH-1:0]     READY,
    input  logic [N_CH-1:0]     ENA_IN,
    input  logic [8*N_CH-1:0]   DATA_IN,
    input  logic [8*N_CH-1:0]   BYTE_INDEX_IN,
    output logic [N_CH-1:0]     RD_REQ,
    output logic [7:0]          DATA_OUT,
    output logic                DVALID_OUT,
    output logic                FRAME_START,
    output logic                FRAME_END,
    output logic [CH_W-1:0]     PLP_ID,
    output logic [15:0]         SYNCD,
    output logic                BUSY,
    output logic                ERR
);

    typedef enum logic [2:0] {IDLE, SELECT, XFER, DRAIN, PAD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     dfl_q, dfl_d;
    logic [15:0]     issued_q, issued_d;
    logic [15:0]     recv_q, recv_d;
    logic [CH_W-1:0] sel_q, sel_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [CH_W-1:0] plp_q, plp_d;
    logic [7:0]      dout_q;
    logic            dvalid_q, fstart_q, fend_q, err_q;

    logic            sync_sel, ready_sel, ena_sel;
    logic [7:0]      data_sel;
    logic            found;
    logic [CH_W-1:0] cand;
    logic            rd_en, take_real, emit, done;

    always_comb begin
        sync_sel  = 1'b0;
        ready_sel = 1'b0;
        ena_sel   = 1'b0;
        data_sel  = 8'h00;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_q == CH_W'(i)) begin
                sync_sel  = SYNC_FOUND[i];
                ready_sel = READY[i];
                ena_sel   = ENA_IN[i];
                data_sel  = DATA_IN[8*i +: 8];
            end
        end
    end

    // Round-robin: first locked channel strictly after the last one served
    always_comb begin
        found = 1'b0;
        cand  = last_q;
        for (int k = 1; k <= N_CH; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found && i == (int'(last_q) + k) % N_CH && SYNC_FOUND[i]) begin
                    found = 1'b1;
                    cand  = CH_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dfl_d     = dfl_q;
        issued_d  = issued_q;
        recv_d    = recv_q;
        sel_d     = sel_q;
        last_d    = last_q;
        plp_d     = plp_q;
        rd_en     = 1'b0;
        take_real = 1'b0;
        emit      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (FRAME_REQ && DFL != 16'd0 && !fend_q) begin
                    dfl_d    = DFL;
                    issued_d = 16'd0;
                    recv_d   = 16'd0;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                if (found) begin
                    sel_d   = cand;
                    plp_d   = cand;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!sync_sel) begin
                    state_d = PAD;
                end else begin
                    rd_en = ready_sel && (issued_q < dfl_q);
                    if (rd_en) issued_d = issued_q + 16'd1;
                    if (issued_d == dfl_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!sync_sel) state_d = PAD;
            end
            PAD: ;
            default: state_d = IDLE;
        endcase

        // A byte already in flight when sync drops is still delivered before padding
        if (state_q == XFER || state_q == DRAIN || state_q == PAD) begin
            take_real = ena_sel;
            emit      = ena_sel || (state_q == PAD);
        end
        if (emit) begin
            recv_d = recv_q + 16'd1;
            if (recv_d == dfl_q) begin
                done    = 1'b1;
                state_d = IDLE;
                last_d  = sel_q;
            end
        end
    end

    always_comb begin
        RD_REQ = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_en && sel_q == CH_W'(i)) RD_REQ[i] = 1'b1;
        end
    end

    always_ff @(posedge DCLK_IN or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            dfl_q    <= 16'd0;
            issued_q <= 16'd0;
            recv_q   <= 16'd0;
            sel_q    <= '0;
            last_q   <= CH_W'(N_CH - 1);
            plp_q    <= '0;
            dout_q   <= 8'h00;
            dvalid_q <= 1'b0;
            fstart_q <= 1'b0;
            fend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dfl_q    <= dfl_d;
            issued_q <= issued_d;
            recv_q   <= recv_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            plp_q    <= plp_d;
            dout_q   <= take_real ? data_sel : 8'h00;
            dvalid_q <= emit;
            fstart_q <= emit && (recv_q == 16'd0);
            fend_q   <= done;
            err_q    <= done && (state_q == PAD);
        end
    end

`ifdef TS_SCHED_SYNCD_EN
    logic [7:0]  bidx_sel;
    logic [15:0] acc_q, acc_d, syncd_q, sd_final;
    logic        hit;

    always_comb begin
        bidx_sel = 8'h00;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_q == CH_W'(i)) bidx_sel = BYTE_INDEX_IN[8*i +: 8];
        end
    end

    // 16'hFFFF doubles as "no packet start seen yet"; recv never reaches it here
    always_comb begin
        acc_d    = acc_q;
        hit      = take_real && (bidx_sel == (NM_or_HEM ? 8'd2 : 8'd1)) && (acc_q == 16'hFFFF);
        if (state_q == IDLE) acc_d = 16'hFFFF;
        if (hit) acc_d = recv_q;
        sd_final = hit ? recv_q : acc_q;
    end

    always_ff @(posedge DCLK_IN or negedge RST) begin
        if (!RST) begin
            acc_q   <= 16'hFFFF;
            syncd_q <= 16'hFFFF;
        end else begin
            acc_q <= acc_d;
            if (done) syncd_q <= sd_final;
        end
    end

    assign SYNCD = syncd_q;
`else
    logic unused_syncd_inputs;
    assign unused_syncd_inputs = ^{NM_or_HEM, BYTE_INDEX_IN};
    assign SYNCD = 16'hFFFF;
`endif

    assign DATA_OUT    = dout_q;
    assign DVALID_OUT  = dvalid_q;
    assign FRAME_START = fstart_q;
    assign FRAME_END   = fend_q;
    assign ERR         = err_q;
    assign PLP_ID      = plp_q;
    assign BUSY        = (state_q != IDLE) || fend_q;

endmodule

// File: tb/tb_ts_frame_scheduler.sv
// tb/tb_ts_frame_scheduler.sv - scoreboard bench for ts_frame_scheduler
module tb_ts_frame_scheduler;
    localparam int N_CH = 2;
    localparam int CH_W = 3;
`ifdef TS_SCHED_SYNCD_EN
    localparam bit SYNCD_EN = 1'b1;
`else
    localparam bit SYNCD_EN = 1'b0;
`endif

    logic                RST, DCLK_IN, FRAME_REQ, NM_or_HEM;
    logic [15:0]         DFL;
    logic [N_CH-1:0]     SYNC_FOUND, READY, ENA_IN, RD_REQ;
    logic [8*N_CH-1:0]   DATA_IN, BYTE_INDEX_IN;
    logic [7:0]          DATA_OUT;
    logic                DVALID_OUT, FRAME_START, FRAME_END, BUSY, ERR;
    logic [CH_W-1:0]     PLP_ID;
    logic [15:0]         SYNCD;

    ts_frame_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .RST(RST), .DCLK_IN(DCLK_IN), .FRAME_REQ(FRAME_REQ), .DFL(DFL),
        .NM_or_HEM(NM_or_HEM), .SYNC_FOUND(SYNC_FOUND), .READY(READY),
        .ENA_IN(ENA_IN), .DATA_IN(DATA_IN), .BYTE_INDEX_IN(BYTE_INDEX_IN),
        .RD_REQ(RD_REQ), .DATA_OUT(DATA_OUT), .DVALID_OUT(DVALID_OUT),
        .FRAME_START(FRAME_START), .FRAME_END(FRAME_END), .PLP_ID(PLP_ID),
        .SYNCD(SYNCD), .BUSY(BUSY), .ERR(ERR)
    );

    initial DCLK_IN = 1'b0;
    always #5 DCLK_IN = ~DCLK_IN;

    typedef struct {
        int          plp;
        int          dfl;
        bit          err;
        logic [15:0] sd;
    } fld_t;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  q_data[$];
    fld_t        q_field[$];
    logic [7:0]  idx_tab[16];
    int          idx_ptr = 0;
    int          n_mon = 0;
    int          fields_done = 0;
    int          rd_cnt = 0;
    int          cyc = 0;
    int          first_rd = -1;
    int          first_dv = -1;
    int          last_dv = -1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sd_exp(input logic [15:0] v);
        return SYNCD_EN ? v : 16'hFFFF;
    endfunction

    // Channel FIFO model: answers every RD_REQ with a random byte one cycle later
    initial begin
        logic [N_CH-1:0] rd_s;
        logic [7:0]      d;
        ENA_IN = '0;
        DATA_IN = '0;
        BYTE_INDEX_IN = '0;
        forever begin
            @(negedge DCLK_IN);
            rd_s = RD_REQ;
            @(posedge DCLK_IN);
            #1;
            ENA_IN = rd_s;
            for (int i = 0; i < N_CH; i++) begin
                if (rd_s[i]) begin
                    d = 8'($urandom_range(0, 255));
                    DATA_IN[8*i +: 8] = d;
                    BYTE_INDEX_IN[8*i +: 8] = (idx_ptr < 16) ? idx_tab[idx_ptr] : 8'd100;
                    idx_ptr++;
                    q_data.push_back(d);
                end
            end
        end
    end

    // Output monitor: real bytes come from q_data in order, pads are 0x00
    initial begin
        fld_t       cur;
        logic [7:0] exp_d;
        bit         last;
        cur = '{0, 1, 1'b0, 16'hFFFF};
        forever begin
            @(negedge DCLK_IN);
            cyc++;
            if (!RST) begin
                n_mon = 0;
            end else begin
                if (RD_REQ != '0) begin
                    rd_cnt++;
                    if (first_rd < 0) first_rd = cyc;
                    chk_eq("rd_without_ready", 32'(RD_REQ & ~READY), 32'd0);
                end
                if (DVALID_OUT) begin
                    if (first_dv < 0) first_dv = cyc;
                    last_dv = cyc;
                    if (n_mon == 0) begin
                        if (q_field.size() == 0) begin
                            chk_eq("field_expected", 32'd0, 32'd1);
                            cur = '{0, 1, 1'b0, 16'hFFFF};
                        end else begin
                            cur = q_field.pop_front();
                        end
                    end
                    exp_d = (q_data.size() > 0) ? q_data.pop_front() : 8'h00;
                    last = (n_mon == cur.dfl - 1);
                    chk_eq("data", 32'(DATA_OUT), 32'(exp_d));
                    chk_eq("plp", 32'(PLP_ID), 32'(cur.plp));
                    chk_eq("fstart", 32'(FRAME_START), 32'(n_mon == 0));
                    chk_eq("fend", 32'(FRAME_END), 32'(last));
                    chk_eq("err", 32'(ERR), 32'(last && cur.err));
                    if (last) begin
                        chk_eq("syncd", 32'(SYNCD), 32'(cur.sd));
                        n_mon = 0;
                        fields_done++;
                    end else begin
                        n_mon++;
                    end
                end
            end
        end
    end

    task automatic req_field(input int plp, input int dfl, input bit err, input logic [15:0] sd);
        q_field.push_back('{plp, dfl, err, sd});
        idx_ptr = 0;
        @(posedge DCLK_IN);
        #1;
        DFL = 16'(dfl);
        FRAME_REQ = 1'b1;
        @(posedge DCLK_IN);
        #1;
        FRAME_REQ = 1'b0;
    endtask

    task automatic wait_done(input int target, input bit toggle);
        int k = 0;
        while (fields_done < target && k < 2000) begin
            @(posedge DCLK_IN);
            #1;
            if (toggle) READY = ~READY;
            k++;
        end
        chk_eq("field_done", 32'(fields_done), 32'(target));
    endtask

    task automatic set_idx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] e);
        for (int i = 0; i < 16; i++) idx_tab[i] = 8'd100;
        idx_tab[0] = a; idx_tab[1] = b; idx_tab[2] = c; idx_tab[3] = d; idx_tab[4] = e;
    endtask

    initial begin
        int k;
        RST = 1'b0;
        FRAME_REQ = 1'b0;
        DFL = 16'd0;
        NM_or_HEM = 1'b0;
        SYNC_FOUND = '0;
        READY = '0;
        set_idx(8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
        repeat (3) @(posedge DCLK_IN);
        @(negedge DCLK_IN);
        chk_eq("rst_dvalid", 32'(DVALID_OUT), 32'd0);
        chk_eq("rst_fend", 32'(FRAME_END), 32'd0);
        chk_eq("rst_busy", 32'(BUSY), 32'd0);
        chk_eq("rst_syncd", 32'(SYNCD), 32'hFFFF);
        chk_eq("rst_rdreq", 32'(RD_REQ), 32'd0);
        @(posedge DCLK_IN);
        #1;
        RST = 1'b1;
        SYNC_FOUND = 2'b11;
        READY = 2'b11;

        // basic field on channel 0, read latency 2
        rd_cnt = 0; first_rd = -1; first_dv = -1;
        req_field(0, 4, 1'b0, 16'hFFFF);
        wait_done(1, 1'b0);
        chk_eq("basic_rd_count", 32'(rd_cnt), 32'd4);
        chk_eq("basic_latency", 32'(first_dv - first_rd), 32'd2);

        // round robin
        req_field(1, 3, 1'b0, 16'hFFFF);
        wait_done(2, 1'b0);
        SYNC_FOUND = 2'b10;
        req_field(1, 3, 1'b0, 16'hFFFF);
        wait_done(3, 1'b0);

        // no channel locked: stays busy without reading
        SYNC_FOUND = 2'b00;
        req_field(0, 3, 1'b0, 16'hFFFF);
        repeat (6) begin
            @(negedge DCLK_IN);
            chk_eq("nolock_busy", 32'(BUSY), 32'd1);
            chk_eq("nolock_rd", 32'(RD_REQ), 32'd0);
        end
        @(posedge DCLK_IN);
        #1;
        SYNC_FOUND = 2'b01;
        wait_done(4, 1'b0);

        // SYNCD cases
        SYNC_FOUND = 2'b11;
        NM_or_HEM = 1'b0;
        set_idx(8'd186, 8'd187, 8'd188, 8'd1, 8'd2);
        req_field(1, 5, 1'b0, sd_exp(16'd3));
        wait_done(5, 1'b0);
        NM_or_HEM = 1'b1;
        set_idx(8'd186, 8'd187, 8'd188, 8'd2, 8'd100);
        req_field(0, 4, 1'b0, sd_exp(16'd3));
        wait_done(6, 1'b0);
        NM_or_HEM = 1'b0;
        set_idx(8'd10, 8'd11, 8'd12, 8'd13, 8'd14);
        req_field(1, 5, 1'b0, 16'hFFFF);
        wait_done(7, 1'b0);
        set_idx(8'd100, 8'd100, 8'd100, 8'd100, 8'd100);

        // READY gaps
        rd_cnt = 0; first_dv = -1;
        req_field(0, 6, 1'b0, 16'hFFFF);
        wait_done(8, 1'b1);
        READY = 2'b11;
        chk_eq("gap_rd_count", 32'(rd_cnt), 32'd6);
        chk_eq("gap_dvalid_span", 32'(last_dv - first_dv + 1 > 6), 32'd1);

        // sync loss after 3 received bytes
        req_field(1, 8, 1'b1, 16'hFFFF);
        k = 0;
        while (n_mon < 3 && k < 100) begin
            @(posedge DCLK_IN);
            #1;
            k++;
        end
        SYNC_FOUND[1] = 1'b0;
        k = 0;
        while (fields_done < 9 && k < 60) begin
            @(negedge DCLK_IN);
            chk_eq("loss_rd", 32'(RD_REQ), 32'd0);
            k++;
        end
        wait_done(9, 1'b0);
        SYNC_FOUND = 2'b11;

        req_field(0, 2, 1'b0, 16'hFFFF);
        wait_done(10, 1'b0);

        // reset mid-transfer on channel 1
        rd_cnt = 0;
        req_field(1, 8, 1'b0, 16'hFFFF);
        k = 0;
        while (rd_cnt < 2 && k < 100) begin
            @(posedge DCLK_IN);
            #1;
            k++;
        end
        RST = 1'b0;
        @(negedge DCLK_IN);
        chk_eq("mid_rst_dvalid", 32'(DVALID_OUT), 32'd0);
        chk_eq("mid_rst_fend", 32'(FRAME_END), 32'd0);
        chk_eq("mid_rst_busy", 32'(BUSY), 32'd0);
        chk_eq("mid_rst_plp", 32'(PLP_ID), 32'd0);
        chk_eq("mid_rst_rdreq", 32'(RD_REQ), 32'd0);
        repeat (2) @(posedge DCLK_IN);
        q_data.delete();
        q_field.delete();
        @(posedge DCLK_IN);
        #1;
        RST = 1'b1;
        chk_eq("mid_rst_no_fend", 32'(fields_done), 32'd10);
        req_field(0, 4, 1'b0, 16'hFFFF);
        wait_done(11, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ts_frame_scheduler.md
# ts_frame_scheduler

Schedules per-PLP TS input channels into baseband-frame data fields for the T2-MI packer. On each downstream frame request it picks one locked channel round-robin and reads exactly DFL bytes from that channel's TS FIFO. It streams the bytes out with frame markers and computes SYNCD, the offset of the first user-packet start in the field. If a channel loses sync mid-field, the field is zero-padded so it keeps its full length.

## Interface
- N_CH, 2: number of input channels, 2..8.
- CH_W, 3: width of PLP_ID, at least clog2(N_CH).
- RST  in  1  async reset, active-low.
- DCLK_IN  in  1  clock; all logic is on its rising edge.
- FRAME_REQ  in  1  single-cycle request for one data field; sampled only in IDLE.
- DFL  in  16  data-field length in bytes; latched on an accepted request.
- NM_or_HEM  in  1  0 = NM (user packet starts at BYTE_INDEX 1); 1 = HEM (starts at BYTE_INDEX 2).
- SYNC_FOUND  in  N_CH  per-channel lock.
- READY  in  N_CH  per-channel FIFO is non-empty.
- ENA_IN  in  N_CH  per-channel read data valid, one cycle after RD_REQ.
- DATA_IN  in  8*N_CH  channel i occupies bits [8i+7:8i].
- BYTE_INDEX_IN  in  8*N_CH  channel i occupies bits [8i+7:8i]; byte position in TS packet, 1..188.
- RD_REQ  out  N_CH  per-channel FIFO read strobe.
- DATA_OUT  out  8  data-field byte.
- DVALID_OUT  out  1  DATA_OUT is valid.
- FRAME_START  out  1  asserted with the first byte of a field.
- FRAME_END  out  1  asserted with the last byte of a field.
- PLP_ID  out  CH_W  channel being served; held stable from FRAME_START through FRAME_END.
- SYNCD  out  16  offset in bytes of the first user-packet start, 16'hFFFF if none; valid with FRAME_END.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- ERR  out  1  one-cycle pulse with FRAME_END if the field was padded.

## Operation
- FSM states: IDLE, SELECT, XFER, DRAIN, PAD.
- **IDLE:** on FRAME_REQ with DFL≠0, latch DFL, clear the counters and go to SELECT. FRAME_REQ with DFL=0 is ignored. FRAME_REQ in any other state is ignored.
- **SELECT:** search from (last+1) mod N_CH upward for the first channel with SYNC_FOUND set. Store it as sel and go to XFER. If no channel is locked, stay in SELECT.
- **XFER:**
  - RD_REQ[sel] = READY[sel] && issued < DFL; all other RD_REQ bits are 0.
  - issued increments on each RD_REQ.
  - When issued reaches DFL, go to DRAIN.
- **DRAIN:** wait until recv == DFL.
- recv increments on each output byte. Output bytes are ENA_IN[sel] bytes accepted in XFER, DRAIN or PAD, plus pad bytes.
- **Sync loss:** if SYNC_FOUND[sel] falls in XFER or DRAIN, stop requesting and go to PAD.
  - PAD: an in-flight ENA_IN byte is still accepted. On every cycle without ENA_IN, a 0x00 byte is emitted. Continue until recv == DFL.
  - A padded field raises ERR.
- **Field completion:** the byte that makes recv == DFL carries FRAME_END. Then set last = sel and return to IDLE.
- **SYNCD:** the recv value of the first accepted real byte whose BYTE_INDEX equals 1 (NM) or 2 (HEM). If no such byte, 16'hFFFF. Pad bytes never match.
- Counters issued and recv are 16-bit, unsigned, and never wrap, since both are bounded by DFL.

## Timing
- Reset values:
  - All outputs are 0, except SYNCD = 16'hFFFF.
  - State is IDLE and last = N_CH-1, so the first field is served by channel 0 if it is locked.
- An accepted FRAME_REQ at cycle t gives SELECT at t+1. The earliest RD_REQ is at t+2.
- Read path: RD_REQ at t gives ENA_IN at t+1, which gives a registered DATA_OUT/DVALID_OUT at t+2. Total latency is 2 cycles.
- A pad byte is registered the same way: 1 cycle from the PAD decision to DATA_OUT.
- FRAME_START, FRAME_END, ERR and SYNCD are registered alongside DATA_OUT.
- If DFL=1, FRAME_START and FRAME_END assert in the same cycle.
- BUSY falls the cycle after FRAME_END.
- The earliest next FRAME_REQ is accepted the cycle after BUSY falls.
- An async reset mid-field aborts immediately: there is no FRAME_END and counters and outputs go to their reset values.

## Configuration
- TS_SCHED_SYNCD_EN defined: SYNCD is computed as described above.
- TS_SCHED_SYNCD_EN undefined: SYNCD is constant 16'hFFFF, the BYTE_INDEX_IN compare logic is removed, and NM_or_HEM is unused. All other behaviour is unchanged.

## Test plan
- **Basic field:** N_CH=2, both channels locked, READY[0]=1 constantly, DFL=4, FRAME_REQ pulse. Expect RD_REQ[0] high for 4 cycles. DATA_OUT carries the 4 bytes starting 2 cycles after the first RD_REQ. FRAME_START is on byte 1, FRAME_END on byte 4, PLP_ID=0, ERR=0.
- **Round-robin:** issue a second request with both channels locked; expect PLP_ID=1. Issue a third with SYNC_FOUND[0]=0; expect PLP_ID=1 again. With no channel locked, expect BUSY=1 and no RD_REQ until a lock appears.
- **SYNCD:** with TS_SCHED_SYNCD_EN defined:
  - NM, DFL=5, indices 186,187,188,1,2: SYNCD=3.
  - HEM, DFL=4, indices 186,187,188,2: SYNCD=3.
  - All indices in 10..14: SYNCD=16'hFFFF.
  - Macro undefined: always 16'hFFFF.
- **READY gaps:** DFL=6 with READY toggling every other cycle. RD_REQ is asserted only when READY is high; exactly 6 bytes are output with gaps in DVALID_OUT and FRAME_END on the 6th.
- **Sync loss:** DFL=8, SYNC_FOUND[sel] drops after 3 bytes have been received. Expect no further RD_REQ, then 0x00 pad bytes until 8 bytes total. FRAME_END and ERR are on byte 8.
- **Reset:** assert RST mid-XFER. All outputs return to reset values with no FRAME_END. The next request is served by channel 0.
